cache_mem_resp: RTL
===================

CACHE_MEM_RESP -- requirements
Module: cache_mem_resp

Interface
REQ-001 SHALL have parameter LINES, default 256, backing-store depth in 512-bit lines (power of 2).
REQ-002 SHALL have parameter LAT, default 4, added wait cycles before a fill read (0 allowed).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_miss  input  1  fill request level, held by the cache until the response.
REQ-006 SHALL have port i_miss_addr  input  32  byte address of the missing line.
REQ-007 SHALL have port i_evict  input  1  writeback request level.
REQ-008 SHALL have port i_evict_addr  input  32  byte address of the evicted line.
REQ-009 SHALL have port i_evict_data  input  512  evicted line data.
REQ-010 SHALL have port o_memory_line  output  512  fill data.
REQ-011 SHALL have port o_memory_response  output  1  one-cycle fill-complete pulse.
REQ-012 SHALL have port o_evict_ack  output  1  one-cycle writeback-complete pulse.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL use FSM states IDLE, WB, WAIT, RD, RESP.
REQ-015 SHALL compute the line index as addr[6+log2(LINES)-1:6] and SHALL ignore addr[5:0] and all higher bits.
REQ-016 SHALL store each line as 16 32-bit words; word k maps to line bits [32k+31:32k].
REQ-017 SHALL sample requests only in IDLE; in other states requests SHALL be ignored and no state SHALL change.
REQ-018 SHALL give i_evict priority when i_evict and i_miss are both high in IDLE; the miss is served afterwards.
REQ-019 SHALL latch the address and data at acceptance (cycle N); later input changes SHALL have no effect.
REQ-020 Writeback timing: WB SHALL span cycles N+1..N+16 and write word k in cycle N+1+k.
REQ-021 o_evict_ack SHALL be high in cycle N+16 only; the FSM SHALL be in IDLE at N+17.
REQ-022 Fill timing: WAIT SHALL span N+1..N+LAT; RD SHALL span N+LAT+1..N+LAT+17.
REQ-023 RD SHALL use one-cycle synchronous reads: issue word k, capture it one cycle later.
REQ-024 RESP SHALL occur at N+LAT+18, with o_memory_response high and o_memory_line fully valid.
REQ-025 o_memory_line SHALL hold its value until the next fill's first capture.
REQ-026 RESP SHALL return to IDLE; the cache SHALL drop i_miss at the edge that ends RESP.
REQ-027 A fill to the line just written back SHALL return the written-back data.

Reset
REQ-028 When rst is high at an edge: state SHALL become IDLE; o_memory_line SHALL be 0; o_memory_response, o_evict_ack and o_busy SHALL be 0; latched address and data SHALL be 0.
REQ-029 Backing-store contents SHALL NOT be cleared by reset.
REQ-030 Reset during WB SHALL abort the writeback; already-written words remain; no ack SHALL be issued.
REQ-031 Reset during WAIT, RD or RESP SHALL abort the fill; no response pulse SHALL be issued.

Configuration
REQ-032 With CACHE_MEM_RESP_STATS_EN defined, the block SHALL add output ports o_fill_count (32 bits) and o_evict_count (32 bits).
REQ-033 The counters SHALL increment on each RESP cycle and each ack cycle respectively, wrap at 2^32, and reset to 0.
REQ-034 Without CACHE_MEM_RESP_STATS_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 Package cache_mem_pkg SHALL hold LINE_BITS=512, WORD_BITS=32, WORDS_PER_LINE=16, OFFSET_BITS=6, and the FSM state enum.
REQ-036 The backing store SHALL be sub-module mem_word_ram: single-port, synchronous read and write, 32-bit words, LINES*16 deep.

Verification
REQ-037 Evict then fill: evict addr 0x0000_0040 with words 0x1000+k → ack at N+16; then miss 0x0000_0044 → response at N+LAT+18 (LAT=4: N+22) with word k = 0x1000+k.
REQ-038 Simultaneous requests: i_evict and i_miss both high in IDLE, same line, evict data 0xA5A5_A5A5 in every word → ack first; the fill then returns 0xA5A5_A5A5 in every word.
REQ-039 LAT=0: miss at cycle N → response at N+18; o_busy high N+1..N+18.
REQ-040 Aliasing: evict to 0x0000_0000, then fill from 0x0000_4000 with LINES=256 → returns the same line.
REQ-041 Reset mid-RD: rst at RD beat 5 → no response pulse; outputs 0; next miss completes normally.
REQ-042 STATS_EN: 3 fills and 2 evicts → o_fill_count=3 and o_evict_count=2; rst → both 0.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg
// Shared constants and FSM state type for the cache memory responder.
// No ports; imported by cache_mem_resp and mem_word_ram.
package cache_mem_pkg;

  localparam int LINE_BITS      = 512;
  localparam int WORD_BITS      = 32;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_BITS    = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    WAIT = 3'd2,
    RD   = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram
// Single-port backing store of 32-bit words, LINES*16 deep.
// Synchronous write and synchronous (registered) read on the same address.
// Contents are deliberately not reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable for the current address
//   addr   - word address {line index, word index}
//   wdata  - write data
//   rdata  - read data, valid one cycle after addr is presented
module mem_word_ram
  import cache_mem_pkg::*;
#(
  parameter int LINES = 256,
  parameter int AW    = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [LINES*WORDS_PER_LINE];

  // Read-first single port; the read data register is free-running.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_resp.sv
// cache_mem_resp
// Memory-side responder for a cache: serves line writebacks (evicts) and
// line fills (misses) against a word-wide backing store, one word per cycle.
// Optional feature macro: CACHE_MEM_RESP_STATS_EN adds fill/evict counters.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   i_miss/i_miss_addr  - fill request level and byte address
//   i_evict/_addr/_data - writeback request level, byte address and line data
//   o_memory_line       - fill data, held until the next fill starts capturing
//   o_memory_response   - one-cycle fill-complete pulse
//   o_evict_ack         - one-cycle writeback-complete pulse
//   o_busy              - high whenever the FSM is not IDLE
//   o_fill_count, o_evict_count (STATS_EN only) - wrapping completion counters
module cache_mem_resp
  import cache_mem_pkg::*;
#(
  parameter int LINES = 256,
  parameter int LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_miss,
  input  logic [31:0]          i_miss_addr,
  input  logic                 i_evict,
  input  logic [31:0]          i_evict_addr,
  input  logic [LINE_BITS-1:0] i_evict_data,
  output logic [LINE_BITS-1:0] o_memory_line,
  output logic                 o_memory_response,
  output logic                 o_evict_ack,
  output logic                 o_busy
`ifdef CACHE_MEM_RESP_STATS_EN
  ,
  output logic [31:0]          o_fill_count,
  output logic [31:0]          o_evict_count
`endif
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int RAM_AW = IDX_W + 4;

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       line_q;
  logic [LINE_BITS-1:0]   data_q;
  logic [31:0]            cnt_q;
  logic [LINE_BITS-1:0]   line_out_q;
  logic                   ack, resp;
  logic                   ram_we;
  logic [RAM_AW-1:0]      ram_addr;
  logic [WORD_BITS-1:0]   ram_wdata, ram_rdata;
  logic [3:0]             cap_idx;
  logic                   unused_addr_bits;

  // Only the line-index field of each address is meaningful.
  assign unused_addr_bits = ^{i_miss_addr[31:OFFSET_BITS+IDX_W], i_miss_addr[OFFSET_BITS-1:0],
                              i_evict_addr[31:OFFSET_BITS+IDX_W], i_evict_addr[OFFSET_BITS-1:0]};

  // The beat counter doubles as the word index in WB and RD and as the
  // latency counter in WAIT; in RD beat j captures word j-1.
  assign ram_addr  = {line_q, cnt_q[3:0]};
  assign ram_wdata = data_q[{cnt_q[3:0], 5'd0} +: WORD_BITS];
  assign cap_idx   = cnt_q[3:0] - 4'd1;
  assign ram_we    = (state == WB) && !rst;

  mem_word_ram #(
    .LINES (LINES),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state and pulse outputs; requests are only looked at in IDLE and
  // an evict wins over a simultaneous miss.
  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_evict) begin
          state_nx = WB;
        end else if (i_miss) begin
          state_nx = (LAT == 0) ? RD : WAIT;
        end
      end
      WB: begin
        if (cnt_q == 32'd15) begin
          ack      = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 32'(LAT - 1)) begin
          state_nx = RD;
        end
      end
      RD: begin
        if (cnt_q == 32'd16) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        resp     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, beat counter, request latch and fill-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_q      <= 32'd0;
      line_q     <= '0;
      data_q     <= '0;
      line_out_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == IDLE) begin
        cnt_q <= 32'd0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (state == IDLE && i_evict) begin
        line_q <= i_evict_addr[OFFSET_BITS +: IDX_W];
        data_q <= i_evict_data;
      end else if (state == IDLE && i_miss) begin
        line_q <= i_miss_addr[OFFSET_BITS +: IDX_W];
      end
      if (state == RD && cnt_q != 32'd0) begin
        line_out_q[{cap_idx, 5'd0} +: WORD_BITS] <= ram_rdata;
      end
    end
  end

  assign o_memory_line     = line_out_q;
  assign o_memory_response = resp;
  assign o_evict_ack       = ack;
  assign o_busy            = (state != IDLE);

`ifdef CACHE_MEM_RESP_STATS_EN
  logic [31:0] fill_cnt_q, evict_cnt_q;

  // Completion counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q  <= 32'd0;
      evict_cnt_q <= 32'd0;
    end else begin
      if (resp) fill_cnt_q  <= fill_cnt_q + 32'd1;
      if (ack)  evict_cnt_q <= evict_cnt_q + 32'd1;
    end
  end

  assign o_fill_count  = fill_cnt_q;
  assign o_evict_count = evict_cnt_q;
`endif

endmodule
